// File: rtl/sdram_pkg.sv
// Shared widths, limits and reader state encoding for the SDRAM burst-read path.
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 25;
    localparam int BURST_LEN_W  = 11;
    localparam int CHUNK_MAX    = 1023;

    // Reader state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    function automatic logic [15:0] chunk_words(input logic [15:0] remaining, input int chunk);
        if (32'(remaining) < 32'(chunk)) begin
            return remaining;
        end
        return 16'(chunk);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with registered occupancy and synchronous reset.
module sync_fifo_fwft #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head word is masked while empty so the output reads zero rather than stale storage
    assign dout = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_burst_reader.sv
// Splits a read job into FIFO-sized bursts and streams the returned words with a last flag.
module sdram_burst_reader
    import sdram_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CHUNK = 32
) (
    input  logic                    controller_clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [SDRAM_ADDR_W-1:0] req_addr,
    input  logic [15:0]             req_words,
    output logic                    burst_rd,
    output logic [SDRAM_ADDR_W-1:0] burst_addr,
    output logic [BURST_LEN_W-1:0]  burst_len,
    output logic                    burst_32bit,
    input  logic [31:0]             burst_data,
    input  logic                    burst_data_valid,
    input  logic                    burst_data_done,
    output logic [31:0]             out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]              state_q, state_d;
    logic [SDRAM_ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [15:0]             remaining_q, remaining_d;
    logic [15:0]             pending_q, pending_d;
    logic                    burst_rd_q, burst_rd_d;
    logic [SDRAM_ADDR_W-1:0] burst_addr_q, burst_addr_d;
    logic [BURST_LEN_W-1:0]  burst_len_q, burst_len_d;
    logic                    overflow_q, overflow_d;

    logic [15:0]   chunk_n;
    logic          room_ok;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty, last_tag;
    logic [CW-1:0] fifo_count;
    logic [32:0]   fifo_dout;

    assign chunk_n   = chunk_words(remaining_q, CHUNK);
    assign room_ok   = (32'(fifo_count) + 32'(chunk_n)) <= 32'(DEPTH);
    assign fifo_push = (state_q == ST_WAIT) && burst_data_valid;
    assign fifo_pop  = !fifo_empty && out_ready;
    assign last_tag  = (remaining_q == 16'd0) && (pending_q == 16'd1);

    sync_fifo_fwft #(
        .WIDTH(33),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (controller_clk),
        .reset(reset),
        .push (fifo_push),
        .pop  (fifo_pop),
        .din  ({last_tag, burst_data}),
        .dout (fifo_dout),
        .count(fifo_count),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        pending_d    = pending_q;
        burst_rd_d   = 1'b0;
        burst_addr_d = burst_addr_q;
        burst_len_d  = burst_len_q;
        overflow_d   = overflow_q | (fifo_push & fifo_full);
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_words != 16'd0) begin
                    state_d     = ST_CHECK;
                    cur_addr_d  = req_addr;
                    remaining_d = req_words;
                end
            end
            ST_CHECK: begin
                // Burst outputs are loaded here so they are registered during ISSUE
                if (room_ok) begin
                    state_d      = ST_ISSUE;
                    burst_rd_d   = 1'b1;
                    burst_addr_d = cur_addr_q;
                    burst_len_d  = BURST_LEN_W'({chunk_n, 1'b0});
                end
            end
            ST_ISSUE: begin
                cur_addr_d  = cur_addr_q + SDRAM_ADDR_W'({chunk_n, 1'b0});
                remaining_d = remaining_q - chunk_n;
                pending_d   = chunk_n;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (burst_data_valid && pending_q != 16'd0) begin
                    pending_d = pending_q - 16'd1;
                end
                if (burst_data_done) begin
                    state_d = (remaining_q != 16'd0) ? ST_CHECK : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge controller_clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            pending_q    <= '0;
            burst_rd_q   <= 1'b0;
            burst_addr_q <= '0;
            burst_len_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            pending_q    <= pending_d;
            burst_rd_q   <= burst_rd_d;
            burst_addr_q <= burst_addr_d;
            burst_len_q  <= burst_len_d;
            overflow_q   <= overflow_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign burst_rd    = burst_rd_q;
    assign burst_addr  = burst_addr_q;
    assign burst_len   = burst_len_q;
    assign burst_32bit = 1'b1;
    assign out_data    = fifo_dout[31:0];
    assign out_last    = fifo_dout[32];
    assign out_valid   = !fifo_empty;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign overflow    = overflow_q;

endmodule
